// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin grant,
// one-cycle operand hold, captured result with zero flag, held until consumed.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [5:0]        req0_func,
  input  logic [1:0]        req0_op,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [5:0]        req1_func,
  input  logic [1:0]        req1_op,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_operation,
  output logic [1:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,

  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state;
  logic   last_grant;  // requester of the most recent (or in-flight) operation
  logic   grant;
  logic   accept;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
    accept     = (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept &&  grant;
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_operation <= '0;
      alu_opcode    <= '0;
      rsp0_valid    <= 1'b0;
      rsp0_result   <= '0;
      rsp0_zero     <= 1'b0;
      rsp1_valid    <= 1'b0;
      rsp1_result   <= '0;
      rsp1_zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a         <= grant ? req1_a    : req0_a;
            alu_b         <= grant ? req1_b    : req0_b;
            alu_operation <= grant ? req1_func : req0_func;
            alu_opcode    <= grant ? req1_op   : req0_op;
            last_grant    <= grant;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          // Operands have been stable for a full cycle; the ALU output is settled.
          if (last_grant) begin
            rsp1_result <= alu_result;
            rsp1_zero   <= (alu_result == '0);
            rsp1_valid  <= 1'b1;
          end else begin
            rsp0_result <= alu_result;
            rsp0_zero   <= (alu_result == '0);
            rsp0_valid  <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (last_grant ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU, expected-result scoreboard,
// immediate-assertion checks and a single summary line.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [5:0]  req0_func = '0, req1_func = '0;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [5:0]  alu_operation;
  logic [1:0]  alu_opcode;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic [31:0] result;
    logic        zero;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_func(req0_func), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_func(req1_func), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .busy(busy)
  );

  // Behavioural shared ALU: opcode 10 add, 01 sub, 11 slt, 00 decodes func.
  function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [5:0] func,
                                            input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b10:   return a + b;
      2'b01:   return a - b;
      2'b11:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        case (func)
          6'b100000: return a + b;
          6'b100010: return a - b;
          6'b100100: return a & b;
          6'b100101: return a | b;
          6'b100111: return ~(a | b);
          6'b101010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default:   return a;
        endcase
      end
    endcase
  endfunction

  assign alu_result = alu_model(alu_opcode, alu_operation, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic id, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] f, input logic [1:0] op);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_func = f; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_func = f; req0_op = op;
    end
  endtask

  task automatic push_exp(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] f, input logic [1:0] op);
    logic [31:0] r;
    r = alu_model(op, f, a, b);
    sb.push_back('{id: id, result: r, zero: (r == 32'd0)});
  endtask

  // Present a request, wait (bounded) for its ready, record the expectation on accept.
  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] f, input logic [1:0] op, input int budget);
    bit done;
    done = 1'b0;
    drive_req(id, a, b, f, op);
    for (int i = 0; i < budget && !done; i++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        push_exp(id, a, b, f, op);
        done = 1'b1;
      end
      tick();
    end
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    check($sformatf("accept_req%0d", id), 32'(done), 32'd1);
  endtask

  task automatic pop_check(input logic id);
    exp_t e;
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_owner", 32'(id), 32'(e.id));
      check($sformatf("rsp%0d_result", id), id ? rsp1_result : rsp0_result, e.result);
      check($sformatf("rsp%0d_zero", id), 32'(id ? rsp1_zero : rsp0_zero), 32'(e.zero));
      check("rsp_other_valid", 32'(id ? rsp0_valid : rsp1_valid), 32'd0);
    end
  endtask

  // Wait (bounded) for the response, score it, consume it and confirm return to IDLE.
  task automatic expect_rsp(input logic id, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i <= budget && !seen; i++) begin
      if ((id ? rsp1_valid : rsp0_valid) === 1'b1) begin
        seen = 1'b1;
        pop_check(id);
        if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("rsp_dropped", 32'(id ? rsp1_valid : rsp0_valid), 32'd0);
        check("idle_after_rsp", 32'(busy), 32'd0);
      end else begin
        tick();
      end
    end
    check($sformatf("rsp%0d_seen", id), 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_cyc[2];
    int n_acc, n_rsp;
    bit took;
    logic [31:0] held;

    // Reset values
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_op", {24'd0, alu_opcode, alu_operation}, 32'd0);
    check("rst_rsp0_result", rsp0_result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // 5 + 7 on req0: latency and alu register contents
    issue(1'b0, 32'd5, 32'd7, 6'b100000, 2'b10, 4);
    check("lat_not_yet", 32'(rsp0_valid), 32'd0);
    check("busy_issue", 32'(busy), 32'd1);
    check("alu_a_issue", alu_a, 32'd5);
    check("alu_b_issue", alu_b, 32'd7);
    check("alu_opcode_issue", 32'(alu_opcode), 32'd2);
    expect_rsp(1'b0, 1);
    check("alu_a_hold_idle", alu_a, 32'd5);

    // 9 - 9 via func decode: zero flag
    issue(1'b0, 32'd9, 32'd9, 6'b100010, 2'b00, 4);
    expect_rsp(1'b0, 2);

    // Ready with nothing pending is ignored
    rsp0_ready = 1'b1;
    tick();
    tick();
    check("stray_ready_valid", 32'(rsp0_valid), 32'd0);
    check("stray_ready_busy", 32'(busy), 32'd0);
    rsp0_ready = 1'b0;

    // Simultaneous requests after reset: req0 first, then req1
    do_reset();
    drive_req(1'b0, 32'hF0, 32'h3C, 6'b100100, 2'b00);
    drive_req(1'b1, 32'hF0, 32'h0F, 6'b100101, 2'b00);
    #1;
    check("tie_ready0", 32'(req0_ready), 32'd1);
    check("tie_ready1", 32'(req1_ready), 32'd0);
    issue(1'b0, 32'hF0, 32'h3C, 6'b100100, 2'b00, 1);
    check("tie_ready1_issue", 32'(req1_ready), 32'd0);
    expect_rsp(1'b0, 2);
    issue(1'b1, 32'hF0, 32'h0F, 6'b100101, 2'b00, 2);
    expect_rsp(1'b1, 2);

    // Backpressure on rsp0 with req1 waiting
    issue(1'b0, 32'd100, 32'd1, 6'b000000, 2'b01, 4);
    drive_req(1'b1, 32'h1234, 32'h0001, 6'b100101, 2'b00);
    tick();
    held = (sb.size() > 0) ? sb[0].result : 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(rsp0_valid), 32'd1);
      check("bp_result_held", rsp0_result, held);
      check("bp_req1_ready", 32'(req1_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    expect_rsp(1'b0, 0);
    check("bp_req1_ready_idle", 32'(req1_ready), 32'd1);
    issue(1'b1, 32'h1234, 32'h0001, 6'b100101, 2'b00, 1);
    expect_rsp(1'b1, 2);

    // Reset during ISSUE drops the operation
    issue(1'b0, 32'd3, 32'd4, 6'b100000, 2'b10, 4);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("mid_rst_alu_a", alu_a, 32'd0);
    check("mid_rst_alu_b", alu_b, 32'd0);
    check("mid_rst_rsp0_result", rsp0_result, 32'd0);
    check("mid_rst_rsp1_result", rsp1_result, 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    end
    drive_req(1'b0, 32'd1, 32'd1, 6'b100000, 2'b10);
    drive_req(1'b1, 32'd2, 32'd2, 6'b100000, 2'b10);
    #1;
    check("post_rst_tie_ready0", 32'(req0_ready), 32'd1);
    check("post_rst_tie_ready1", 32'(req1_ready), 32'd0);
    issue(1'b0, 32'd1, 32'd1, 6'b100000, 2'b10, 1);
    req1_valid = 1'b0;
    expect_rsp(1'b0, 2);

    // Back-to-back req0 with rsp0_ready tied high
    rsp0_ready = 1'b1;
    n_acc = 0;
    n_rsp = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    drive_req(1'b0, 32'd20, 32'd22, 6'b100000, 2'b10);
    for (int c = 0; c < 20 && n_rsp < 2; c++) begin
      #1;
      took = 1'b0;
      if (rsp0_valid === 1'b1) begin
        pop_check(1'b0);
        n_rsp++;
      end
      if (req0_ready === 1'b1 && n_acc < 2) begin
        acc_cyc[n_acc] = c;
        if (n_acc == 0) push_exp(1'b0, 32'd20, 32'd22, 6'b100000, 2'b10);
        else            push_exp(1'b0, 32'd7, 32'd7, 6'b100010, 2'b00);
        n_acc++;
        took = 1'b1;
      end
      tick();
      if (took) begin
        if (n_acc == 1) drive_req(1'b0, 32'd7, 32'd7, 6'b100010, 2'b00);
        else            req0_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    rsp0_ready = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd2);
    check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    check("b2b_responses", 32'(n_rsp), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
